branch_compare_pipe: RTL and testbench

Parametrised, pipelined operand comparator for the MIPS datapath. It replaces single-function, purely combinational equality checking with an eight-mode comparator covering equality and signed/unsigned ordering. It has a two-stage registered pipeline, valid/ready handshakes on both sides, a pass-through tag and a synchronous flush. It sits between the register-read stage and the branch-resolution logic, and the branch unit consumes its single-bit result.

---
 rtl/branch_compare_pipe.sv | 142 ++++++++++++++
 tb/tb_branch_compare_pipe.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_compare_pipe.sv
// Two-stage pipelined 8-mode operand comparator (EQ/NE/signed and unsigned ordering) with pass-through tag.
// Latency: result valid two cycles after the input is accepted; one comparison per cycle sustained.
// Backpressure: out/out_tag hold while out_valid & !out_ready; S1 holds when S2 is blocked; flush kills both stages.
module branch_compare_pipe #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       mode,
    input  logic [TAG_W-1:0] tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out,
    output logic [TAG_W-1:0] out_tag
);

    // WIDTH must be even and >= 2 so both halves are non-empty.
    localparam int LO = WIDTH / 2;

    localparam logic [2:0] MODE_EQ  = 3'd0;
    localparam logic [2:0] MODE_NE  = 3'd1;
    localparam logic [2:0] MODE_LT  = 3'd2;
    localparam logic [2:0] MODE_LTU = 3'd3;
    localparam logic [2:0] MODE_LE  = 3'd4;
    localparam logic [2:0] MODE_GT  = 3'd5;
    localparam logic [2:0] MODE_GE  = 3'd6;
    localparam logic [2:0] MODE_GEU = 3'd7;

    logic             s1_valid;
    logic             s1_hi_eq;
    logic             s1_hi_lts;
    logic             s1_hi_ltu;
    logic             s1_lo_eq;
    logic             s1_lo_ltu;
    logic [2:0]       s1_mode;
    logic [TAG_W-1:0] s1_tag;

    logic             s2_adv;
    logic             s1_adv;
    logic             in_fire;

    logic             hi_eq_d;
    logic             hi_lts_d;
    logic             hi_ltu_d;
    logic             lo_eq_d;
    logic             lo_ltu_d;

    logic             eq;
    logic             lts;
    logic             ltu;
    logic             result;

    assign s2_adv   = !out_valid | out_ready;
    assign s1_adv   = !s1_valid | s2_adv;
    assign in_ready = s1_adv & !flush;
    assign in_fire  = in_valid & in_ready;

    // Split compare: the signed view only matters in the upper half, whose MSB is the operand sign.
    always_comb begin
        hi_eq_d  = (a[WIDTH-1:LO] == b[WIDTH-1:LO]);
        hi_lts_d = ($signed(a[WIDTH-1:LO]) < $signed(b[WIDTH-1:LO]));
        hi_ltu_d = (a[WIDTH-1:LO] < b[WIDTH-1:LO]);
        lo_eq_d  = (a[LO-1:0] == b[LO-1:0]);
        lo_ltu_d = (a[LO-1:0] < b[LO-1:0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_hi_eq  <= 1'b0;
            s1_hi_lts <= 1'b0;
            s1_hi_ltu <= 1'b0;
            s1_lo_eq  <= 1'b0;
            s1_lo_ltu <= 1'b0;
            s1_mode   <= 3'd0;
            s1_tag    <= '0;
        end else if (in_fire) begin
            s1_hi_eq  <= hi_eq_d;
            s1_hi_lts <= hi_lts_d;
            s1_hi_ltu <= hi_ltu_d;
            s1_lo_eq  <= lo_eq_d;
            s1_lo_ltu <= lo_ltu_d;
            s1_mode   <= mode;
            s1_tag    <= tag;
        end
    end

    always_comb begin
        eq  = s1_hi_eq & s1_lo_eq;
        lts = s1_hi_lts | (s1_hi_eq & s1_lo_ltu);
        ltu = s1_hi_ltu | (s1_hi_eq & s1_lo_ltu);
        result = 1'b0;
        case (s1_mode)
            MODE_EQ:  result = eq;
            MODE_NE:  result = !eq;
            MODE_LT:  result = lts;
            MODE_LTU: result = ltu;
            MODE_LE:  result = lts | eq;
            MODE_GT:  result = !(lts | eq);
            MODE_GE:  result = !lts;
            MODE_GEU: result = !ltu;
            default:  result = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
        end
    end

    // Data only moves when a real entry advances, so a stalled result stays put.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out     <= 1'b0;
            out_tag <= '0;
        end else if (s2_adv && s1_valid) begin
            out     <= result;
            out_tag <= s1_tag;
        end
    end

endmodule

// File: tb/tb_branch_compare_pipe.sv
// Randomized + directed bench for branch_compare_pipe; scoreboard fed by a full-width arithmetic reference.
module tb_branch_compare_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  mode;
    logic [3:0]  tag;
    logic        out_valid;
    logic        out_ready;
    logic        out;
    logic [3:0]  out_tag;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic       r;
        logic [3:0] t;
    } exp_t;

    exp_t       sb_q[$];
    logic       hold_prev = 1'b0;
    logic       prev_out;
    logic [3:0] prev_tag;
    logic [3:0] next_tag = 4'd1;

    branch_compare_pipe #(.WIDTH(32), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .mode(mode), .tag(tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic ref_cmp(input logic [31:0] x, input logic [31:0] y, input logic [2:0] m);
        case (m)
            3'd0: return x == y;
            3'd1: return x != y;
            3'd2: return $signed(x) < $signed(y);
            3'd3: return x < y;
            3'd4: return $signed(x) <= $signed(y);
            3'd5: return $signed(x) > $signed(y);
            3'd6: return $signed(x) >= $signed(y);
            default: return x >= y;
        endcase
    endfunction

    function automatic logic [31:0] special(input int k);
        case (k)
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            default: return 32'h7FFF_FFFF;
        endcase
    endfunction

    // Output-side stability and scoreboard, sampled mid-cycle while inputs are settled.
    always @(negedge clk) begin
        if (rst_n) begin
            if (hold_prev) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_out", out, prev_out);
                chk("stall_tag", out_tag, prev_tag);
            end
            hold_prev = out_valid & !out_ready & !flush;
            prev_out  = out;
            prev_tag  = out_tag;
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) chk("spurious_out", 1, 0);
                else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("sb_out", out, e.r);
                    chk("sb_tag", out_tag, e.t);
                end
            end
            if (flush) begin
                chk("flush_blocks_in", in_ready, 0);
                sb_q.delete();
            end
            if (in_valid && in_ready) sb_q.push_back({ref_cmp(a, b, mode), tag});
        end
    end

    always @(negedge rst_n) begin
        sb_q.delete();
        hold_prev = 1'b0;
    end

    task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [2:0] m, input logic [3:0] t);
        logic got;
        got = 1'b0;
        in_valid = 1'b1; a = x; b = y; mode = m; tag = t;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) chk("send_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Single directed comparison into an empty pipe, checking the two-cycle latency.
    task automatic vec(input string name, input logic [31:0] x, input logic [31:0] y,
                       input logic [2:0] m, input logic e);
        logic [3:0] t;
        t = next_tag;
        next_tag = next_tag + 4'd1;
        out_ready = 1'b1;
        send(x, y, m, t);
        @(negedge clk);
        chk({name, "_early"}, out_valid, 0);
        @(negedge clk);
        chk({name, "_valid"}, out_valid, 1);
        chk(name, out, e);
        chk({name, "_tag"}, out_tag, t);
        @(posedge clk); #1;
    endtask

    task automatic drain_check(input string name);
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk(name, sb_q.size(), 0);
        chk({name, "_valid"}, out_valid, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; mode = '0; tag = '0;
        repeat (2) @(posedge clk); #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out", out, 0);
        chk("rst_out_tag", out_tag, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        vec("eq",        32'h1234_5678, 32'h1234_5678, 3'd0, 1'b1);
        vec("ne",        32'h1234_5678, 32'h1234_5679, 3'd1, 1'b1);
        vec("lt_neg",    32'hFFFF_FFFF, 32'h0000_0001, 3'd2, 1'b1);
        vec("ltu_neg",   32'hFFFF_FFFF, 32'h0000_0001, 3'd3, 1'b0);
        vec("ge_neg",    32'hFFFF_FFFF, 32'h0000_0001, 3'd6, 1'b0);
        vec("geu_neg",   32'hFFFF_FFFF, 32'h0000_0001, 3'd7, 1'b1);
        vec("gt_min",    32'h8000_0000, 32'h7FFF_FFFF, 3'd5, 1'b0);
        vec("ltu_half",  32'h0001_0000, 32'h0000_FFFF, 3'd3, 1'b0);
        vec("gt_half",   32'h0001_0000, 32'h0000_FFFF, 3'd5, 1'b1);
        vec("ltu_lo",    32'h0001_1234, 32'h0001_FFFF, 3'd3, 1'b1);
        vec("lt_lo",     32'h8001_1234, 32'h8001_FFFF, 3'd2, 1'b1);
        vec("le_eq",     32'hDEAD_BEEF, 32'hDEAD_BEEF, 3'd4, 1'b1);

        // Back-to-back stream: tags 0..7 on consecutive cycles.
        out_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send($urandom, $urandom, 3'($urandom_range(0, 7)), 4'(i));
            end
            begin
                for (int k = 0; k < 12; k++) begin
                    @(negedge clk);
                    if (out_valid) break;
                end
                for (int i = 0; i < 8; i++) begin
                    chk("stream_valid", out_valid, 1);
                    chk("stream_tag", out_tag, 32'(i));
                    if (i < 7) @(negedge clk);
                end
            end
        join
        drain_check("stream_drain");

        // Backpressure: two entries fill the pipe, a third waits.
        out_ready = 1'b0;
        send($urandom, $urandom, 3'd0, 4'd8);
        send($urandom, $urandom, 3'd1, 4'd9);
        @(negedge clk);
        chk("bp_full_in_ready", in_ready, 0);
        chk("bp_full_valid", out_valid, 1);
        chk("bp_full_tag", out_tag, 8);
        @(posedge clk); #1;
        fork
            send($urandom, $urandom, 3'd3, 4'd10);
            begin
                repeat (5) begin
                    @(negedge clk);
                    chk("bp_hold_in_ready", in_ready, 0);
                    chk("bp_hold_tag", out_tag, 8);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain_check("bp_drain");

        // Flush with two in flight; input during flush must be dropped.
        out_ready = 1'b0;
        send(32'h5, 32'h5, 3'd0, 4'd11);
        send(32'h5, 32'h5, 3'd0, 4'd12);
        in_valid = 1'b1; tag = 4'd13; flush = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", in_ready, 0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("flush_out_valid", out_valid, 0);
        @(negedge clk);
        chk("flush_s1_empty", out_valid, 0);
        @(posedge clk); #1;
        vec("post_flush", 32'h0000_0003, 32'h0000_0007, 3'd2, 1'b1);

        // Asynchronous reset mid-stream.
        out_ready = 1'b0;
        send(32'hA, 32'hA, 3'd0, 4'd14);
        send(32'hA, 32'hA, 3'd0, 4'd15);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out", out, 0);
        chk("arst_out_tag", out_tag, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        chk("arst_in_ready", in_ready, 1);
        chk("arst_no_glitch", out_valid, 0);
        @(posedge clk); #1;
        vec("post_reset", 32'h7FFF_0000, 32'h8000_0000, 3'd6, 1'b1);

        // Random traffic with random backpressure and occasional flush.
        for (int c = 0; c < 800; c++) begin
            logic [31:0] x, y;
            int p;
            x = ($urandom_range(0, 3) == 0) ? special($urandom_range(0, 3)) : $urandom;
            p = $urandom_range(0, 4);
            case (p)
                0: y = x;
                1: y = {x[31:16], 16'($urandom)};
                2: y = {16'($urandom), x[15:0]};
                3: y = special($urandom_range(0, 3));
                default: y = $urandom;
            endcase
            a = x; b = y;
            mode      = 3'($urandom_range(0, 7));
            tag       = 4'($urandom);
            in_valid  = ($urandom_range(0, 9) < 6);
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 99) < 3);
            @(posedge clk); #1;
        end
        drain_check("rand_drain");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
